// File: rtl/mag_comp_seq.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned.
// Latency: done pulses n edges after the accept edge (n = first differing digit, or N if equal).
// Backpressure: none; start is ignored while busy, with no queuing.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, signed_mode  compare request and mode (1 = two's complement), sampled when idle
//   a, b                WIDTH-bit operands, sampled with start
//   busy, done          compare in progress / one-cycle result-valid pulse
//   a_gt_b/a_lt_b/a_eq_b  registered result flags, held until the next accepted start
//   digits              number of digits examined for the last result (1..WIDTH/DIGIT)
module mag_comp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                signed_mode,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  output logic                                busy,
  output logic                                done,
  output logic                                a_gt_b,
  output logic                                a_lt_b,
  output logic                                a_eq_b,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]    digits
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CMP  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    count;

  // Flipping the sign bit maps two's complement onto offset binary, so the
  // unsigned digit walk below yields the signed ordering.
  logic [WIDTH-1:0] sign_flip;
  assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  logic [DIGIT-1:0] top_a;
  logic [DIGIT-1:0] top_b;
  assign top_a = sh_a[WIDTH-1 -: DIGIT];
  assign top_b = sh_b[WIDTH-1 -: DIGIT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
      digits <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a   <= a ^ sign_flip;
            sh_b   <= b ^ sign_flip;
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
            digits <= '0;
            count  <= CW'(1);
            busy   <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          if (top_a != top_b) begin
            // First differing digit decides; later digits are irrelevant.
            a_gt_b <= (top_a > top_b);
            a_lt_b <= (top_a < top_b);
            digits <= count;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (count == LAST) begin
            a_eq_b <= 1'b1;
            digits <= LAST;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            sh_a  <= sh_a << DIGIT;
            sh_b  <= sh_b << DIGIT;
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comp_seq.sv
module tb_mag_comp_seq;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   n;
    int   cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  // DIGIT=1 instance
  logic       start1 = 1'b0, sm1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, gt1, lt1, eq1;
  logic [3:0] dig1;

  // DIGIT=4 instance
  logic       start4 = 1'b0, sm4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, gt4, lt4, eq4;
  logic [1:0] dig4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t q1[$];
  exp_t q4[$];

  mag_comp_seq #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .signed_mode(sm1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1), .digits(dig1)
  );

  mag_comp_seq #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .a_gt_b(gt4), .a_lt_b(lt4), .a_eq_b(eq4), .digits(dig4)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a start pulse (caller is at a negedge) and push the expected result.
  task automatic req(input bit sel4, input logic [7:0] av, input logic [7:0] bv, input bit sm,
                     input bit gt, input bit lt, input bit eq, input int n);
    exp_t e;
    e.gt = gt; e.lt = lt; e.eq = eq; e.n = n; e.cyc = cyc + 1 + n;
    if (sel4) begin
      a4 = av; b4 = bv; sm4 = sm; start4 = 1'b1; q4.push_back(e);
    end else begin
      a1 = av; b1 = bv; sm1 = sm; start1 = 1'b1; q1.push_back(e);
    end
  endtask

  task automatic pulse(input bit sel4, input logic [7:0] av, input logic [7:0] bv, input bit sm,
                       input bit gt, input bit lt, input bit eq, input int n);
    @(negedge clock);
    req(sel4, av, bv, sm, gt, lt, eq, n);
    @(negedge clock);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clock);
      #1;
      if (q1.size() == 0 && q4.size() == 0) break;
    end
    total++;
    assert (q1.size() == 0 && q4.size() == 0) else begin
      bad++;
      $error("FAIL %s_timeout got=%0d/%0d pending exp=0", tag, q1.size(), q4.size());
    end
  endtask

  // Scoreboard monitors: pop and compare whenever a done pulse is seen.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done1) begin
      total++;
      assert (q1.size() > 0) else begin
        bad++;
        $error("FAIL d1_spurious_done got=1 exp=0");
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_gt", 32'(gt1), 32'(e.gt));
        chk("d1_lt", 32'(lt1), 32'(e.lt));
        chk("d1_eq", 32'(eq1), 32'(e.eq));
        chk("d1_digits", 32'(dig1), 32'(e.n));
        chk("d1_latency", 32'(cyc), 32'(e.cyc));
        chk("d1_busy_at_done", 32'(busy1), 32'd0);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && done4) begin
      total++;
      assert (q4.size() > 0) else begin
        bad++;
        $error("FAIL d4_spurious_done got=1 exp=0");
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("d4_gt", 32'(gt4), 32'(e.gt));
        chk("d4_lt", 32'(lt4), 32'(e.lt));
        chk("d4_eq", 32'(eq4), 32'(e.eq));
        chk("d4_digits", 32'(dig4), 32'(e.n));
        chk("d4_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int k;
    bit seen;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_flags", {29'd0, gt1, lt1, eq1}, 32'd0);
    chk("rst_digits", 32'(dig1), 32'd0);

    // Unsigned 10 vs 9: bit 1 differs -> digit 7
    pulse(1'b0, 8'd10, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0, 7);
    drain("gt_10_9");

    // 15 vs 15 equal, then 2 vs 11 started in the done cycle
    pulse(1'b0, 8'd15, 8'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL eq15_done_wait got=0 exp=1");
    end
    req(1'b0, 8'd2, 8'd11, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    @(negedge clock);
    start1 = 1'b0;
    chk("b2b_busy", 32'(busy1), 32'd1);
    chk("b2b_flags_clear", {29'd0, gt1, lt1, eq1}, 32'd0);
    chk("b2b_digits_clear", 32'(dig1), 32'd0);
    drain("b2b");

    // 1 vs -10: signed and unsigned disagree at the MSB
    pulse(1'b0, 8'd1, 8'hF6, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    drain("signed");
    pulse(1'b0, 8'd1, 8'hF6, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    drain("unsigned");

    // DIGIT=4 instance
    pulse(1'b1, 8'h3A, 8'h3B, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    drain("d4_lt");
    pulse(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    drain("d4_eq");

    // Start while busy is ignored, operand changes mid-compare have no effect
    pulse(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    a1 = 8'hFF; b1 = 8'h01; sm1 = 1'b1; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk("ignored_busy", 32'(busy1), 32'd1);
    drain("ignored");
    repeat (10) @(negedge clock);
    chk("ignored_no_extra", 32'(busy1), 32'd0);

    // Asynchronous reset in the third CMP cycle
    pulse(1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8);
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_done", 32'(done1), 32'd0);
    chk("arst_flags", {29'd0, gt1, lt1, eq1}, 32'd0);
    chk("arst_digits", 32'(dig1), 32'd0);
    q1.delete();
    @(negedge clock);
    reset = 1'b0;
    // 0xC3 vs 0xC7: bit 2 differs -> digit 6
    pulse(1'b0, 8'hC3, 8'hC7, 1'b0, 1'b0, 1'b1, 1'b0, 6);
    drain("after_reset");

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mag_comp_seq.md
Name: mag_comp_seq

Overview:
Parametrised, sequential MSB-first magnitude comparator with a start/done handshake. It compares two WIDTH-bit operands DIGIT bits per cycle and supports both signed and unsigned modes. It terminates early at the first differing digit and reports how many digits were examined. It is the multi-cycle, width-generic successor to the combinational 4-bit comparator, for use where a wide compare must not sit in one combinational path.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- DIGIT, 1, bits compared per cycle; WIDTH must be an integer multiple of DIGIT.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; sampled only when idle.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- a_gt_b  output  1  A > B.
- a_lt_b  output  1  A < B.
- a_eq_b  output  1  A == B.
- digits  output  clog2(WIDTH/DIGIT+1)  number of digits examined for the last result (1..WIDTH/DIGIT).

Behaviour:
- Reset (async, any time, including mid-compare): state=IDLE, busy=0, done=0, a_gt_b=a_lt_b=a_eq_b=0, digits=0, internal operand registers=0.
- Define N = WIDTH/DIGIT.
- FSM has two states, IDLE and CMP.
- IDLE:
  - On start=1 at a rising edge, capture a and b into shift registers.
  - If signed_mode=1, invert the MSB of both captured copies (offset-binary), so an unsigned compare yields the signed result.
  - Clear all three flags and digits to 0. Load count=1. Go to CMP; busy=1 from this edge.
- CMP, at each edge, compare the top DIGIT bits of the two shift registers:
  - Digits differ: set a_gt_b or a_lt_b accordingly, digits=count, done=1, busy=0, go to IDLE.
  - Digits equal and count==N: set a_eq_b=1, digits=N, done=1, busy=0, go to IDLE.
  - Otherwise: shift both registers left by DIGIT, count+=1, stay in CMP.
- Latency: a start accepted at edge k gives done=1 after edge k+n, where n is the index (1..N) of the first differing digit, or n=N if the operands are equal.
- Throughput: at most one compare per n+1 cycles.
- done is exactly one cycle wide. It deasserts at the next edge unless a decision occurs at that edge, which cannot happen because CMP lasts at least one cycle.
- Flags and digits hold their values after done until the next accepted start, which clears them at the accept edge.
- Exactly one flag is high whenever done=1. All flags are 0 while busy=1.
- start while busy=1 is ignored. No queuing; a, b and signed_mode changes during CMP have no effect.
- start is accepted in the same cycle done=1 is high, since state is IDLE then. That produces back-to-back compares with one idle-free gap.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, DIGIT=1, unsigned, a=10, b=9, pulse start → done after 7 cycles; a_gt_b=1, digits=7.
- WIDTH=8, DIGIT=1, a=b=15 → done after 8 cycles; a_eq_b=1, digits=8. Then a=2, b=11, start in the done cycle → accepted; flags clear at that edge; 5 cycles later a_lt_b=1, digits=5.
- WIDTH=8, DIGIT=1, a=1, b=8'hF6 (-10):
  - signed_mode=1 → a_gt_b=1, digits=1.
  - Repeat with signed_mode=0 → a_lt_b=1, digits=1.
- WIDTH=8, DIGIT=4, a=8'h3A, b=8'h3B → done after 2 cycles; a_lt_b=1, digits=2. Then a=b=8'h80, signed → a_eq_b=1, digits=2.
- Start a 0 vs 0 compare, pulse start again and change a/b on cycle 2 → ignored; result a_eq_b=1 after 8 cycles; only one done pulse seen.
- Assert reset during cycle 3 of CMP, asynchronously between edges → busy, done, flags and digits go to 0 immediately. After release, a new start completes normally.
